td4_prog_ctrl: RTL and testbench
================================

TD4_PROG_CTRL -- requirements
Module: td4_prog_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of clk cycles cpu_reset is held high after a load completes, range 1-15.
REQ-002 Parameter HALT_ADR, default 4'b1111: CPU fetch address that ends a run.
REQ-003 clk  input  1  single clock; every register changes only on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; takes effect immediately, independent of clk.
REQ-005 start  input  1  level-sampled request to begin a program load.
REQ-006 wr_valid  input  1  program byte valid.
REQ-007 wr_ready  output  1  controller accepts a program byte this cycle.
REQ-008 wr_data  input  8  program byte, written in address order 0..15.
REQ-009 cpu_reset  output  1  drives the CPU reset input.
REQ-010 cpu_adr  input  4  CPU fetch address (PC).
REQ-011 cpu_instr  output  8  instruction byte returned to the CPU.
REQ-012 busy  output  1  high in LOAD, RESET_HOLD and RUN.
REQ-013 done  output  1  high in HALT.

Function
REQ-014 The block SHALL hold a 16x8 program memory, a 4-bit write pointer, a 4-bit hold counter and a state register with states IDLE, LOAD, RESET_HOLD, RUN and HALT.
REQ-015 IDLE: cpu_reset=1, wr_ready=0, cpu_instr=8'h00; start=1 -> LOAD with pointer cleared to 0.
REQ-016 LOAD: cpu_reset=1, wr_ready=1, cpu_instr=8'h00; each cycle with wr_valid=1 writes mem[pointer]=wr_data and increments pointer.
REQ-017 LOAD: acceptance of the byte at pointer 15 -> RESET_HOLD with hold counter cleared; the pointer wraps to 0; start is ignored in LOAD.
REQ-018 RESET_HOLD: cpu_reset=1, wr_ready=0; after exactly RST_CYCLES cycles in this state -> RUN.
REQ-019 RUN: cpu_reset=0; cpu_instr=mem[cpu_adr], combinational, zero cycle latency.
REQ-020 RUN: cpu_adr==HALT_ADR in a cycle -> HALT on the next edge; cpu_instr in that cycle is still mem[HALT_ADR].
REQ-021 HALT: cpu_reset=0; cpu_instr={4'b1111,HALT_ADR}, an unconditional jump to itself, so the CPU spins and keeps its output port value.
REQ-022 start=1 in RUN or HALT -> LOAD with pointer cleared to 0; cpu_reset=1 from the next cycle; memory contents are retained until overwritten.
REQ-023 start and the HALT_ADR condition in the same RUN cycle: start wins.
REQ-024 wr_valid outside LOAD SHALL be ignored, and the memory SHALL not change.

Reset
REQ-025 reset=1 SHALL force IDLE, pointer=0, hold counter=0, all memory bytes=8'h00, cpu_reset=1, wr_ready=0, busy=0, done=0 and cpu_instr=8'h00.
REQ-026 reset asserted in any state, including mid-LOAD or in RUN, SHALL discard the partial load and return to IDLE.

Configuration
REQ-027 With macro TD4_PROG_CTRL_CNT_EN defined, the block SHALL add output exec_cnt (8 bits).
REQ-028 exec_cnt SHALL clear on reset and on entry to RUN, increment once per RUN cycle, saturate at 8'hFF and hold its value in HALT.
REQ-029 Without TD4_PROG_CTRL_CNT_EN, neither the port nor the counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-030 Scenario 1: reset, then start=1 for 1 cycle, then 16 bytes with wr_valid held high -> wr_ready=1 for exactly 16 cycles, cpu_reset=1 for 2 further cycles, then busy=1 and cpu_reset=0.
REQ-031 Scenario 2: load byte 0=8'h01 and byte 1=8'hE0, connect to the CPU and run -> cpu_instr=8'h01 when cpu_adr=0 and 8'hE0 when cpu_adr=1.
REQ-032 Scenario 3: HALT_ADR=4'hF and the program jumps to 15 -> done=1 one cycle after cpu_adr=15, then cpu_instr=8'hFF held.
REQ-033 Scenario 4: wr_valid toggling 1,0,1 during LOAD -> only the bytes in valid cycles are stored, at consecutive addresses.
REQ-034 Scenario 5: reset pulse after 7 bytes are loaded -> IDLE, mem[0..6]=8'h00; a fresh 16-byte load then completes normally.
REQ-035 Scenario 6 (TD4_PROG_CTRL_CNT_EN): run for 300 cycles -> exec_cnt=8'hFF; start -> exec_cnt holds 8'hFF until the next RUN entry, then reads 0.

Source files
------------

// File: rtl/td4_prog_ctrl.sv
// TD4 program loader/controller: streams a 16-byte program into local memory, holds the CPU in reset, then serves fetches.
// Optional TD4_PROG_CTRL_CNT_EN adds exec_cnt, a saturating count of RUN cycles.
module td4_prog_ctrl #(
  parameter int unsigned RST_CYCLES = 2,
  parameter logic [3:0]  HALT_ADR   = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       cpu_reset,
  input  logic [3:0] cpu_adr,
  output logic [7:0] cpu_instr,
  output logic       busy,
  output logic       done
`ifdef TD4_PROG_CTRL_CNT_EN
  ,
  output logic [7:0] exec_cnt
`endif
);

  localparam int unsigned ADR_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADR_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                wr_en;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, write pointer and hold counter
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + ADR_W'(1);
          if (ptr_q == ADR_W'(DEPTH - 1)) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        // A reload request outranks reaching the halt address
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end else if (cpu_adr == HALT_ADR) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; cpu_instr is a zero-latency memory read while running
  always_comb begin
    wr_ready  = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    cpu_instr = '0;
    unique case (state_q)
      S_LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
      end
      S_HOLD: busy = 1'b1;
      S_RUN: begin
        cpu_reset = 1'b0;
        busy      = 1'b1;
        cpu_instr = mem_q[cpu_adr];
      end
      S_HALT: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        cpu_instr = {4'b1111, HALT_ADR};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      hold_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
    end
  end

  // Program memory; cleared on reset so a partial load never survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[ptr_q] <= wr_data;
    end
  end

`ifdef TD4_PROG_CTRL_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Restart on RUN entry, count RUN cycles, saturate, hold elsewhere
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign exec_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_td4_prog_ctrl.sv
// Directed bench for td4_prog_ctrl: load/hold/run/halt flow, gapped loads, reset mid-load and mid-run.
module tb_td4_prog_ctrl;

  localparam int unsigned RST_CYCLES = 2;
  localparam logic [3:0]  HALT_ADR   = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       cpu_reset;
  logic [3:0] cpu_adr;
  logic [7:0] cpu_instr;
  logic       busy;
  logic       done;
`ifdef TD4_PROG_CTRL_CNT_EN
  logic [7:0] exec_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] prog  [16];
  logic [7:0] model [16];

  always #5 clk = ~clk;

  td4_prog_ctrl #(
    .RST_CYCLES(RST_CYCLES),
    .HALT_ADR  (HALT_ADR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .cpu_reset(cpu_reset),
    .cpu_adr  (cpu_adr),
    .cpu_instr(cpu_instr),
    .busy     (busy),
    .done     (done)
`ifdef TD4_PROG_CTRL_CNT_EN
    ,
    .exec_cnt (exec_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_prog(input int base);
    for (int i = 0; i < 16; i++) prog[i] = 8'(base + i);
  endtask

  // Start pulse, then 16 accepted bytes; toggle inserts an idle cycle after each byte
  task automatic load_prog(input bit toggle);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("load_done", 32'(done), 32'd0);
    chk("load_instr", 32'(cpu_instr), 32'd0);
    while (idx < 16) begin
      if (toggle && (cyc % 2 == 1)) begin
        wr_valid = 1'b0;
        wr_data  = 8'hAA;
      end else begin
        wr_valid   = 1'b1;
        wr_data    = prog[idx];
        model[idx] = prog[idx];
        idx++;
      end
      start = toggle && (cyc == 3);
      #1;
      chk("load_ready", 32'(wr_ready), 32'd1);
      step();
      cyc++;
    end
    wr_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic hold_to_run();
    for (int c = 0; c < int'(RST_CYCLES); c++) begin
      chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("hold_ready", 32'(wr_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      step();
    end
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
  endtask

  task automatic read_chk(input logic [3:0] a);
    cpu_adr = a;
    #1;
    chk($sformatf("instr_adr%0d", a), 32'(cpu_instr), 32'(model[a]));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_instr"}, 32'(cpu_instr), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    cpu_adr  = 4'h0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    step();
    step();
    idle_chk("rst");
    reset = 1'b0;
    step();
    idle_chk("idle");

    // Full load, reset hold, then fetches
    fill_prog(8'h30);
    prog[0] = 8'h01;
    prog[1] = 8'hE0;
    load_prog(1'b0);
    hold_to_run();
    cpu_adr = 4'h0;
    #1;
    chk("s2_adr0", 32'(cpu_instr), 32'h01);
    cpu_adr = 4'h1;
    #1;
    chk("s2_adr1", 32'(cpu_instr), 32'hE0);
    for (int a = 2; a < 15; a++) read_chk(4'(a));

    // Writes outside LOAD must not land in memory
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    cpu_adr  = 4'h2;
    step();
    step();
    wr_valid = 1'b0;
    cpu_adr  = 4'h0;
    #1;
    chk("stray_wr_adr0", 32'(cpu_instr), 32'h01);

    // Halt address: still served this cycle, HALT next
    cpu_adr = HALT_ADR;
    #1;
    chk("halt_adr_instr", 32'(cpu_instr), 32'h3F);
    chk("halt_adr_done", 32'(done), 32'd0);
    step();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_instr", 32'(cpu_instr), 32'hFF);
    chk("halt_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("halt_busy", 32'(busy), 32'd0);
    cpu_adr = 4'h3;
    step();
    chk("halt_hold_instr", 32'(cpu_instr), 32'hFF);
    chk("halt_hold_done", 32'(done), 32'd1);

    // Reload from HALT with gapped writes and a stray start mid-load
    cpu_adr = 4'h0;
    fill_prog(8'h80);
    load_prog(1'b1);
    hold_to_run();
    for (int a = 0; a < 16; a++) read_chk(4'(a));
    step();
    chk("s4_halt", 32'(done), 32'd1);

    // Reset after 7 bytes of a new load
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'hC0 + i);
      step();
    end
    wr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    idle_chk("async_rst_load");
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    step();
    idle_chk("post_rst_idle");
    cpu_adr = 4'h0;
    fill_prog(8'h20);
    load_prog(1'b0);
    hold_to_run();
    for (int a = 0; a < 7; a++) read_chk(4'(a));

    // Start and halt address together: reload wins
    cpu_adr = HALT_ADR;
    start   = 1'b1;
    step();
    start   = 1'b0;
    cpu_adr = 4'h0;
    chk("prio_busy", 32'(busy), 32'd1);
    chk("prio_done", 32'(done), 32'd0);
    chk("prio_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("prio_ready", 32'(wr_ready), 32'd1);

    fill_prog(8'h60);
    load_prog(1'b0);
    hold_to_run();
`ifdef TD4_PROG_CTRL_CNT_EN
    chk("cnt_run_entry", 32'(exec_cnt), 32'h00);
    repeat (5) step();
    chk("cnt_run5", 32'(exec_cnt), 32'h05);
    cpu_adr = HALT_ADR;
    step();
    cpu_adr = 4'h0;
    chk("cnt_halt_done", 32'(done), 32'd1);
    repeat (3) step();
    chk("cnt_halt_hold", 32'(exec_cnt), 32'h06);
    load_prog(1'b0);
    chk("cnt_load_hold", 32'(exec_cnt), 32'h06);
    hold_to_run();
    chk("cnt_rerun_clear", 32'(exec_cnt), 32'h00);
    repeat (300) step();
    chk("cnt_sat", 32'(exec_cnt), 32'hFF);
    load_prog(1'b0);
    chk("cnt_sat_hold", 32'(exec_cnt), 32'hFF);
    hold_to_run();
    chk("cnt_sat_clear", 32'(exec_cnt), 32'h00);
`endif

    // Reset while running
    read_chk(4'h5);
    step();
    #2;
    reset = 1'b1;
    #1;
    idle_chk("async_rst_run");
`ifdef TD4_PROG_CTRL_CNT_EN
    chk("cnt_rst", 32'(exec_cnt), 32'h00);
`endif
    step();
    reset = 1'b0;
    step();
    idle_chk("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
